// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Package : audio_pkg
// Desc    : Shared audio constants and sample type for the codec TX/RX paths.
// Rev     : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int AUD_SAMPLE_W    = 16;
    localparam int AUD_SLOT_W      = 32;
    localparam int AUD_FRAME_BCLKS = 2 * AUD_SLOT_W;

    typedef struct packed {
        logic [AUD_SAMPLE_W-1:0] left;
        logic [AUD_SAMPLE_W-1:0] right;
    } stereo_sample_t;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module : sample_fifo
// Desc   : Synchronous circular FIFO; head is visible on data_out when non-empty.
// Rev    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr;
    logic [C_PTR_W-1:0] r_rd;
    logic [C_LVL_W-1:0] r_level;

    logic               w_do_push;
    logic               w_do_pop;
    logic [C_PTR_W-1:0] w_wr_next;
    logic [C_PTR_W-1:0] w_rd_next;

    assign full      = (r_level == C_LVL_W'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign data_out  = r_mem[r_rd];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign w_wr_next = (r_wr == C_PTR_W'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
    assign w_rd_next = (r_rd == C_PTR_W'(DEPTH - 1)) ? '0 : r_rd + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= data_in;
                r_wr        <= w_wr_next;
            end
            if (w_do_pop) begin
                r_rd <= w_rd_next;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module : i2s_dac_tx
// Desc   : I2S master transmitter to the codec DAC with a small sample FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W   = AUD_SAMPLE_W,
    parameter int SLOT_W     = AUD_SLOT_W,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [2*SAMPLE_W-1:0]           sample_in,
    input  logic                            sample_valid,
    output logic                            sample_ready,
    output logic                            aud_bclk,
    output logic                            aud_daclrck,
    output logic                            aud_dacdat,
    output logic                            underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int C_DATA_W     = 2 * SAMPLE_W;
    localparam int C_FRAME_BITS = 2 * SLOT_W;
    localparam int C_DIV_W      = $clog2(BCLK_DIV);
    localparam int C_B_W        = $clog2(C_FRAME_BITS);

    logic [C_DIV_W-1:0]  r_div;
    logic                r_bclk;
    logic [C_B_W-1:0]    r_b;
    logic                r_lrck;
    logic                r_dat;
    logic                r_underrun;
    logic [C_DATA_W-1:0] r_shift;

    logic                w_div_wrap;
    logic                w_fall;
    logic                w_frame_start;
    logic [C_B_W-1:0]    w_b_next;
    logic                w_data_bit;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [C_DATA_W-1:0] w_head;

    assign w_div_wrap    = (r_div == C_DIV_W'(BCLK_DIV - 1));
    assign w_fall        = w_div_wrap & r_bclk;
    assign w_b_next      = (r_b == C_B_W'(C_FRAME_BITS - 1)) ? '0 : r_b + 1'b1;
    assign w_frame_start = w_fall & (r_b == C_B_W'(C_FRAME_BITS - 1));

    // One-bit I2S delay: data bits occupy b = 1..SAMPLE_W of each slot.
    assign w_data_bit = ((w_b_next >= C_B_W'(1)) && (w_b_next <= C_B_W'(SAMPLE_W))) ||
                        ((w_b_next >= C_B_W'(SLOT_W + 1)) &&
                         (w_b_next <= C_B_W'(SLOT_W + SAMPLE_W)));

    assign sample_ready = ~w_full;
    assign w_push       = sample_valid & sample_ready;
    assign w_pop        = w_frame_start & ~w_empty;

    sample_fifo #(
        .WIDTH (C_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .pop      (w_pop),
        .data_in  (sample_in),
        .data_out (w_head),
        .level    (fifo_level),
        .full     (w_full),
        .empty    (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div      <= '0;
            r_bclk     <= 1'b0;
            r_b        <= '0;
            r_lrck     <= 1'b0;
            r_dat      <= 1'b0;
            r_underrun <= 1'b0;
            r_shift    <= '0;
        end else begin
            r_div      <= w_div_wrap ? '0 : r_div + 1'b1;
            r_underrun <= w_frame_start & w_empty;
            if (w_div_wrap) begin
                r_bclk <= ~r_bclk;
            end
            if (w_fall) begin
                r_b    <= w_b_next;
                r_lrck <= (w_b_next >= C_B_W'(SLOT_W));
                if (w_frame_start) begin
                    r_shift <= w_empty ? '0 : w_head;
                    r_dat   <= 1'b0;
                end else if (w_data_bit) begin
                    // Left bits drain first, leaving the right word at the MSB.
                    r_dat   <= r_shift[C_DATA_W-1];
                    r_shift <= {r_shift[C_DATA_W-2:0], 1'b0};
                end else begin
                    r_dat <= 1'b0;
                end
            end
        end
    end

    assign aud_bclk    = r_bclk;
    assign aud_daclrck = r_lrck;
    assign aud_dacdat  = r_dat;
    assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Playback end of the audio path: accepts 32-bit processed samples from the volume/pitch datapath, one per frame, each packed as {left[15:0], right[15:0]}.
- Serializes them to the codec DAC as I2S master, generating BCLK and LRCK from the system clock.
- A small FIFO decouples the datapath's sample strobe from the codec frame timing.
- Underruns are flagged; silence is sent when no sample is available.

Parameters:
SAMPLE_W, 16, bits per channel; sample_in width is 2*SAMPLE_W
SLOT_W, 32, BCLK periods per channel slot; must be >= SAMPLE_W+1
BCLK_DIV, 4, clk cycles per BCLK half-period; must be >= 2
FIFO_DEPTH, 2, sample entries buffered; must be >= 1

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets on next clk edge)
sample_in  in  2*SAMPLE_W  {left, right}, two's complement
sample_valid  in  1  producer offers sample_in this cycle
sample_ready  out  1  FIFO can accept; transfer = valid & ready
aud_bclk  out  1  bit clock to codec
aud_daclrck  out  1  0 = left slot, 1 = right slot
aud_dacdat  out  1  serial data, MSB first
underrun  out  1  one-cycle pulse: frame started with FIFO empty
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (reset==0): all outputs 0 except sample_ready=1.
  - div counter, bit index b, FIFO and shift register cleared.
  - Reset mid-frame aborts the frame; buffered samples are discarded.
- sample_ready = (fifo_level < FIFO_DEPTH), combinational from the registered count.
- A push with valid & ready writes at the tail; the entry is visible next cycle.
- Clock generation:
  - div counts 0..BCLK_DIV-1 and wraps.
  - aud_bclk toggles on each wrap, so one BCLK period = 2*BCLK_DIV clk cycles.
  - aud_bclk is 0 for the first half of each period.
- Bit index b (0..2*SLOT_W-1) advances at each BCLK falling edge, i.e. at the start of each period, and wraps.
- aud_daclrck = (b >= SLOT_W), registered and changing together with b.
- aud_dacdat, changing only at BCLK falling edges (I2S one-bit delay):
  - Left: b in 1..SAMPLE_W carries left[SAMPLE_W-b].
  - Right: b in SLOT_W+1..SLOT_W+SAMPLE_W carries right[SAMPLE_W-(b-SLOT_W)].
  - All other slots carry 0.
  - Data is stable across the BCLK rising edge, where the codec samples it.
- Frame load, on the clk cycle where b wraps to 0:
  - If the FIFO is non-empty: pop the head into the frame shift register.
  - If the FIFO is empty: load zeros and pulse underrun for exactly that cycle.
  - The first frame after reset release loads zeros without underrun.
- Simultaneous push and pop:
  - Level unchanged; both actions take effect.
  - When full, ready is already 0 that cycle, so there is no push.
  - When empty, the pop sees empty (underrun, zeros sent) and the push still lands; there is no bypass.
- No sample is lost or duplicated across push/pop overlap.
- Default frame: 64 BCLK = 512 clk cycles.

Decomposition:
- Shared package `audio_pkg`:
  - SAMPLE_W constant.
  - stereo_sample_t typedef {left, right}.
  - Slot/frame length constants, reused by the matching ADC receiver.
- One natural sub-module: `sample_fifo`, a synchronous circular FIFO with parameter DEPTH.
  - Ports: push, pop, data in, data out, level, full, empty.
- The clock divider, bit indexing and shifter stay in the top module.

Test Plan:
- Reset: hold reset=0 for 5 cycles with valid=1 -> bclk/lrck/dacdat/underrun/fifo_level all 0, sample_ready=1, no sample stored; release -> first BCLK rising edge 4 clks later.
- Single sample: push 32'hA5A5_3C3C during frame 0 -> frame 1 bits at b=1..16 read 1010010110100101, b=33..48 read 0011110000111100, all other bits 0, lrck high for b 32..63, no underrun.
- Backpressure: hold valid with 3 distinct samples -> first two accepted, fifo_level=2, ready=0 until next frame load, third accepted the cycle after the pop, frames output in push order.
- Underrun: no pushes after frame 1 -> underrun high exactly 1 clk at each frame boundary, dacdat 0 for the whole frame, bclk/lrck keep running.
- Push/pop collision: empty FIFO, push on the exact frame-load cycle -> underrun pulses, zeros sent, fifo_level=1 next cycle, and that sample appears in the following frame.
- Mid-frame reset: assert reset at b=20 with fifo_level=1 -> next cycle all outputs 0, level 0; after release, a silent frame with no underrun.
